// File: rtl/btn_debounce.sv
// Multi-button debouncer with press/release pulse generation.
// Samples synchronized buttons on rising edges of clkdiv[TICK_BIT]; clkdiv is used only as data.
module btn_debounce #(
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned TICK_BIT   = 17,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      clkdiv,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [N_BTN-1:0]            s1_q, s2_q;
  logic                        tick_prev_q;
  logic [N_BTN-1:0][1:0]       state_q, state_d;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            press_q, press_d;
  logic [N_BTN-1:0]            release_q, release_d;
  logic                        tick_c;
  logic                        unused_clkdiv_c;

  assign tick_c          = clkdiv[TICK_BIT] & ~tick_prev_q;
  assign unused_clkdiv_c = ^clkdiv;

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  // tick_prev resets high so the first cycle after reset can never be a tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      tick_prev_q <= 1'b1;
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= ST_IDLE;
      end
      cnt_q       <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
    end else begin
      s1_q        <= btn_in;
      s2_q        <= s1_q;
      tick_prev_q <= clkdiv[TICK_BIT];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  // Per-button next state; pulses flag entry into a settled state from the other side
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (tick_c) begin
        case (state_q[i])
          ST_IDLE: begin
            if (s2_q[i]) begin
              if (STABLE_CNT == 1) begin
                state_d[i] = ST_PRESSED;
                press_d[i] = 1'b1;
              end else begin
                state_d[i] = ST_PRESS_WAIT;
                cnt_d[i]   = ONE_CNT;
              end
            end
          end
          ST_PRESS_WAIT: begin
            if (!s2_q[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == LAST_CNT) begin
              state_d[i] = ST_PRESSED;
              cnt_d[i]   = '0;
              press_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_CNT;
            end
          end
          ST_PRESSED: begin
            if (!s2_q[i]) begin
              if (STABLE_CNT == 1) begin
                state_d[i]   = ST_IDLE;
                release_d[i] = 1'b1;
              end else begin
                state_d[i] = ST_RELEASE_WAIT;
                cnt_d[i]   = ONE_CNT;
              end
            end
          end
          ST_RELEASE_WAIT: begin
            if (s2_q[i]) begin
              state_d[i] = ST_PRESSED;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == LAST_CNT) begin
              state_d[i]   = ST_IDLE;
              cnt_d[i]     = '0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE_CNT;
            end
          end
        endcase
      end
      level_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_RELEASE_WAIT);
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: hand sequences, a vector table and random stimulus against a run-length model.
module tb_btn_debounce;

  localparam int unsigned N = 5;

  typedef struct {
    logic [N-1:0] btn;
    int           hold;
    logic [N-1:0] e_lvl;
    logic [N-1:0] e_prs;
    logic [N-1:0] e_rel;
  } vec_t;

  logic         clk;
  logic         rst;
  logic [31:0]  clkdiv;
  logic [N-1:0] btn_in;
  logic [N-1:0] lvl0, prs0, rel0;
  logic [N-1:0] lvl1, prs1, rel1;

  int n_err = 0;
  int n_chk = 0;
  int pc[N];
  int rc[N];

  // reference model state: [0] = STABLE_CNT 4 build, [1] = STABLE_CNT 1 build
  logic [N-1:0] m_s1, m_s2;
  logic         m_tp;
  logic [N-1:0] m_lvl[2];
  logic [N-1:0] m_prs[2];
  logic [N-1:0] m_rel[2];
  int           m_run[2][N];
  bit           m_valid = 1'b0;

  btn_debounce #(.N_BTN(5), .TICK_BIT(2), .STABLE_CNT(4), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .btn_in(btn_in),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0)
  );

  btn_debounce #(.N_BTN(5), .TICK_BIT(2), .STABLE_CNT(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .btn_in(btn_in),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clkdiv = 32'd0;
    forever begin
      @(negedge clk);
      clkdiv = clkdiv + 32'd1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
        pc[i] += int'(prs0[i]);
        rc[i] += int'(rel0[i]);
      end
    end
  endtask

  task automatic clr();
    for (int i = 0; i < int'(N); i++) begin
      pc[i] = 0;
      rc[i] = 0;
    end
  endtask

  // bit i = button i pulsed at least once, top bit = some button pulsed more than once
  function automatic logic [N:0] cmask(input bit rel);
    logic [N:0] m;
    m = '0;
    for (int i = 0; i < int'(N); i++) begin
      int c;
      c = rel ? rc[i] : pc[i];
      if (c != 0) m[i] = 1'b1;
      if (c > 1) m[N] = 1'b1;
    end
    return m;
  endfunction

  // A change is accepted after STABLE_CNT consecutive ticks that see s2 differ from the level
  always begin : ref_model
    logic         r_s, cd_s, tk;
    logic [N-1:0] b_s;
    int           need;
    @(posedge clk);
    r_s  = rst;
    b_s  = btn_in;
    cd_s = clkdiv[2];
    #1;
    if (!r_s) begin
      m_s1 = '0;
      m_s2 = '0;
      m_tp = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_lvl[k] = '0;
        m_prs[k] = '0;
        m_rel[k] = '0;
        for (int i = 0; i < int'(N); i++) m_run[k][i] = 0;
      end
      m_valid = 1'b1;
    end else begin
      tk   = cd_s & ~m_tp;
      m_tp = cd_s;
      for (int k = 0; k < 2; k++) begin
        need     = (k == 0) ? 4 : 1;
        m_prs[k] = '0;
        m_rel[k] = '0;
        if (tk) begin
          for (int i = 0; i < int'(N); i++) begin
            if (m_s2[i] != m_lvl[k][i]) begin
              m_run[k][i]++;
              if (m_run[k][i] >= need) begin
                m_run[k][i] = 0;
                m_lvl[k][i] = m_s2[i];
                if (m_s2[i]) m_prs[k][i] = 1'b1;
                else         m_rel[k][i] = 1'b1;
              end
            end else begin
              m_run[k][i] = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = b_s;
    end
    if (m_valid) begin
      check("model_sc4", 32'({lvl0, prs0, rel0}), 32'({m_lvl[0], m_prs[0], m_rel[0]}));
      check("model_sc1", 32'({lvl1, prs1, rel1}), 32'({m_lvl[1], m_prs[1], m_rel[1]}));
      check("press_release_excl", 32'((prs0 & rel0) | (prs1 & rel1)), 32'd0);
    end
  end

  initial begin
    vec_t         tbl[13];
    int           t0, t1;
    bit           found, first;
    logic [N-1:0] lv_prev, got;

    tbl[0]  = '{5'b00001, 60, 5'b00001, 5'b00001, 5'b00000};
    tbl[1]  = '{5'b00000, 60, 5'b00000, 5'b00000, 5'b00001};
    tbl[2]  = '{5'b11000, 60, 5'b11000, 5'b11000, 5'b00000};
    tbl[3]  = '{5'b11010, 60, 5'b11010, 5'b00010, 5'b00000};
    tbl[4]  = '{5'b00010, 60, 5'b00010, 5'b00000, 5'b11000};
    tbl[5]  = '{5'b00110,  4, 5'b00010, 5'b00000, 5'b00000};
    tbl[6]  = '{5'b00010, 60, 5'b00010, 5'b00000, 5'b00000};
    tbl[7]  = '{5'b00011, 60, 5'b00011, 5'b00001, 5'b00000};
    tbl[8]  = '{5'b00010,  8, 5'b00011, 5'b00000, 5'b00000};
    tbl[9]  = '{5'b00011, 60, 5'b00011, 5'b00000, 5'b00000};
    tbl[10] = '{5'b00000, 60, 5'b00000, 5'b00000, 5'b00011};
    tbl[11] = '{5'b11111, 60, 5'b11111, 5'b11111, 5'b00000};
    tbl[12] = '{5'b00000, 60, 5'b00000, 5'b00000, 5'b11111};

    rst    = 1'b0;
    btn_in = '0;
    clr();
    hold(4);
    check("reset_sc4", 32'({lvl0, prs0, rel0}), 32'd0);
    check("reset_sc1", 32'({lvl1, prs1, rel1}), 32'd0);
    rst = 1'b1;
    hold(20);

    // clean press: SC=1 build accepts on the first tick, SC=4 build three ticks (24 clk) later
    clr();
    btn_in  = 5'b00001;
    t0      = -1;
    t1      = -1;
    lv_prev = lvl0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int j = 0; j < int'(N); j++) pc[j] += int'(prs0[j]);
      if (prs1[0] && t1 < 0) t1 = i;
      if (prs0[0] && t0 < 0) begin
        t0 = i;
        check("press_level_edge", 32'({lv_prev[0], lvl0[0]}), 32'b01);
      end
      lv_prev = lvl0;
    end
    check("press_seen", 32'({t0 >= 0, t1 >= 0}), 32'b11);
    check("press_gap_sc4_vs_sc1", 32'(t0 - t1), 32'd24);
    check("clean_press_mask", 32'(cmask(1'b0)), 32'({1'b0, 5'b00001}));
    check("clean_press_level", 32'(lvl0), 32'(5'b00001));

    // release
    clr();
    btn_in = '0;
    hold(60);
    check("release_mask", 32'(cmask(1'b1)), 32'({1'b0, 5'b00001}));
    check("release_no_press", 32'(cmask(1'b0)), 32'd0);
    check("release_level", 32'(lvl0), 32'd0);

    // bounce on button 1, then settle high
    clr();
    for (int s = 0; s < 6; s++) begin
      btn_in[1] = (s % 2 == 0);
      hold(10);
    end
    check("bounce_quiet", 32'({cmask(1'b0), cmask(1'b1)}), 32'd0);
    clr();
    btn_in[1] = 1'b1;
    hold(60);
    check("bounce_settled", 32'(cmask(1'b0)), 32'({1'b0, 5'b00010}));
    btn_in = '0;
    hold(60);

    // reset while button 2 is two ticks into its press debounce and button 0 is pressed
    btn_in = 5'b00001;
    hold(60);
    btn_in = 5'b00101;
    found  = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_lvl[0][2] == 1'b0 && m_run[0][2] == 2) found = 1'b1;
    end
    check("reach_cnt2", 32'(found), 32'd1);
    rst = 1'b0;
    hold(1);
    check("midrst_sc4", 32'({lvl0, prs0, rel0}), 32'd0);
    check("midrst_sc1", 32'({lvl1, prs1, rel1}), 32'd0);
    hold(1);
    rst = 1'b1;
    clr();
    hold(60);
    check("post_reset_press", 32'(cmask(1'b0)), 32'({1'b0, 5'b00101}));
    check("post_reset_level", 32'(lvl0), 32'(5'b00101));
    btn_in = '0;
    hold(60);

    // simultaneous press on buttons 3 and 4
    btn_in = 5'b11000;
    first  = 1'b0;
    got    = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prs0 != '0 && !first) begin
        first = 1'b1;
        got   = prs0;
      end
    end
    check("simultaneous_press", 32'(got), 32'(5'b11000));
    btn_in = '0;
    hold(60);

    for (int v = 0; v < 13; v++) begin
      clr();
      btn_in = tbl[v].btn;
      hold(tbl[v].hold);
      check($sformatf("vec%0d_level", v), 32'(lvl0), 32'(tbl[v].e_lvl));
      check($sformatf("vec%0d_press", v), 32'(cmask(1'b0)), 32'({1'b0, tbl[v].e_prs}));
      check($sformatf("vec%0d_release", v), 32'(cmask(1'b1)), 32'({1'b0, tbl[v].e_rel}));
    end

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        hold(int'($urandom_range(1, 3)));
        rst = 1'b1;
      end
      btn_in = 5'($urandom);
      hold(int'($urandom_range(1, 70)));
    end
    hold(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
